dds_par_writer: RTL and testbench
=================================

DDS_PAR_WRITER -- requirements
Module: dds_par_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, DDS parallel address width.
REQ-002 SHALL have parameter DATA_W, default 8, DDS parallel data width.
REQ-003 SHALL have parameter DEPTH, default 16, command FIFO entries; power of 2, at least 2.
REQ-004 SHALL have parameters T_SETUP=2, T_WR=2, T_HOLD=1, RST_CYCLES=10, UD_CYCLES=4, giving phase lengths in CLK cycles; each at least 1.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 S_VALID  in  1  command valid.
REQ-008 S_READY  out  1  FIFO can accept a command.
REQ-009 S_ADDR  in  ADDR_W  target register address.
REQ-010 S_DATA  in  DATA_W  byte to write.
REQ-011 S_LAST  in  1  last byte of a configuration set; an IO update follows it.
REQ-012 MR_REQ  in  1  single-cycle request for a DDS master reset.
REQ-013 AOUT  out  ADDR_W  DDS address bus.
REQ-014 DOUT  out  DATA_W  DDS data bus.
REQ-015 WRB  out  1  active-low write strobe.
REQ-016 RESET  out  1  DDS master reset, active-high.
REQ-017 UDCLK  out  1  DDS IO-update pulse, active-high.
REQ-018 BUSY  out  1  high in every state except IDLE.
REQ-019 DONE  out  1  one-cycle pulse when an update completes.
REQ-020 LEVEL  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-021 A push SHALL occur on an edge where S_VALID and S_READY are both high; S_READY SHALL equal (not full) and (not RST).
REQ-022 Each FIFO entry SHALL be {LAST,ADDR,DATA}; entries SHALL be popped in order at the last HOLD cycle.
REQ-023 FSM states SHALL be IDLE, MRESET, SETUP, STROBE, HOLD, UPDATE.
REQ-024 MR_REQ SHALL set a sticky pending flag; the flag SHALL clear on entry to MRESET.
REQ-025 In IDLE, a pending reset SHALL take priority over a non-empty FIFO, so IDLE goes to MRESET; otherwise a non-empty FIFO SHALL send IDLE to SETUP.
REQ-026 MRESET SHALL drive RESET high for exactly RST_CYCLES cycles, then return to IDLE.
REQ-027 SETUP SHALL drive AOUT/DOUT from the FIFO head with WRB high for T_SETUP cycles.
REQ-028 STROBE SHALL drive WRB low for T_WR cycles.
REQ-029 HOLD SHALL drive WRB high with AOUT/DOUT held for T_HOLD cycles.
REQ-030 After HOLD, the next state SHALL be:
- UPDATE if the entry had LAST set;
- otherwise MRESET if a reset is pending;
- otherwise SETUP if the FIFO is non-empty (back-to-back writes, no IDLE cycle);
- otherwise IDLE.
REQ-031 UPDATE SHALL drive UDCLK high for UD_CYCLES cycles, then pulse DONE for one cycle, then go to IDLE.
REQ-032 A byte SHALL occupy exactly T_SETUP+T_WR+T_HOLD cycles; the first SETUP cycle SHALL begin on the edge after a push into an empty FIFO while IDLE.
REQ-033 AOUT and DOUT SHALL be 0 in IDLE, MRESET and UPDATE.
REQ-034 MR_REQ arriving mid-byte SHALL NOT truncate the current byte; it SHALL be serviced per REQ-025/REQ-030.
REQ-035 A push while full SHALL be impossible; when full, a pop and a push SHALL occur on separate edges.
REQ-036 Phase counters SHALL saturate-free count down from the parameter value minus 1, and be wide enough for the largest parameter.

Reset
REQ-037 While RST is high:
- FSM SHALL be IDLE and the FIFO empty;
- the pending flag SHALL be 0;
- outputs SHALL be AOUT=0, DOUT=0, WRB=1, RESET=0, UDCLK=0, BUSY=0, DONE=0, LEVEL=0, S_READY=0.
REQ-038 RST asserted mid-operation SHALL abort immediately, with WRB returning high asynchronously.

Structure
REQ-039 Package dds_pkg SHALL hold the state enum and the default parameter constants.
REQ-040 The FIFO SHALL be sub-module dds_cmd_fifo (DEPTH, width ADDR_W+DATA_W+1, registered outputs).

Verification
REQ-041 Single write: push {0,0x04,0xA5} -> AOUT=0x04, DOUT=0xA5 for 5 cycles, WRB low in cycles 3-4, then IDLE, no UDCLK.
REQ-042 Burst: push 6 FTW bytes (0x09..0x04), LAST on the last -> 30 contiguous write cycles, then UDCLK high for 4 cycles, then DONE for 1 cycle.
REQ-043 Full: push 17 entries with DEPTH=16 and writer stalled -> S_READY=0 at LEVEL=16; 17th accepted after the first pop.
REQ-044 Reset request during a write: MR_REQ in STROBE of byte 1 of 3 -> byte 1 completes, RESET high for 10 cycles, then bytes 2-3 are written.
REQ-045 Async reset: RST pulse in STROBE -> WRB=1 same cycle, LEVEL=0, all outputs at their reset values.
REQ-046 Parameter sweep: T_SETUP=1, T_WR=3, T_HOLD=2 -> 6 cycles per byte, WRB low for exactly 3.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default timing for the DDS parallel-port writer.
// Phase lengths are in CLK cycles.
package dds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MRESET,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_UPDATE
  } state_t;

  localparam int DDS_ADDR_W     = 6;
  localparam int DDS_DATA_W     = 8;
  localparam int DDS_DEPTH      = 16;
  localparam int DDS_T_SETUP    = 2;
  localparam int DDS_T_WR       = 2;
  localparam int DDS_T_HOLD     = 1;
  localparam int DDS_RST_CYCLES = 10;
  localparam int DDS_UD_CYCLES  = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// Command FIFO: first-word-fall-through head, registered flags and level.
// Memory is plain flops so the head is valid the cycle after a push.
module dds_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_lvl;
  logic          r_empty;
  logic          r_full;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_lvl_nxt;

  assign w_push    = i_push & ~r_full;
  assign w_pop     = i_pop & ~r_empty;
  assign w_lvl_nxt = r_lvl + {{AW{1'b0}}, w_push}
                           - {{AW{1'b0}}, w_pop};

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_lvl   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_lvl   <= w_lvl_nxt;
      r_empty <= (w_lvl_nxt == '0);
      r_full  <= (w_lvl_nxt == (AW+1)'(DEPTH));
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_level = r_lvl;

endmodule

// File: rtl/dds_par_writer.sv
// Parallel-bus writer for a DDS: queues register writes, strobes them out
// with setup/strobe/hold timing, issues IO updates and master resets.
module dds_par_writer
  import dds_pkg::*;
#(
  parameter int ADDR_W     = DDS_ADDR_W,
  parameter int DATA_W     = DDS_DATA_W,
  parameter int DEPTH      = DDS_DEPTH,
  parameter int T_SETUP    = DDS_T_SETUP,
  parameter int T_WR       = DDS_T_WR,
  parameter int T_HOLD     = DDS_T_HOLD,
  parameter int RST_CYCLES = DDS_RST_CYCLES,
  parameter int UD_CYCLES  = DDS_UD_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic [ADDR_W-1:0]      S_ADDR,
  input  logic [DATA_W-1:0]      S_DATA,
  input  logic                   S_LAST,
  input  logic                   MR_REQ,
  output logic [ADDR_W-1:0]      AOUT,
  output logic [DATA_W-1:0]      DOUT,
  output logic                   WRB,
  output logic                   RESET,
  output logic                   UDCLK,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [$clog2(DEPTH):0] LEVEL
);

  localparam int FW   = ADDR_W + DATA_W + 1;
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int MAXP = max2(max2(max2(T_SETUP, T_WR),
                                  max2(T_HOLD, RST_CYCLES)),
                             UD_CYCLES);
  localparam int CW   = cnt_w(MAXP);

  state_t            r_state;
  state_t            w_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_len;
  logic              r_pend;
  logic              r_done;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_end;
  logic              w_more;
  logic              w_ld;
  logic [FW-1:0]     w_head;
  logic              w_hlast;
  logic [ADDR_W-1:0] w_haddr;
  logic [DATA_W-1:0] w_hdata;
  logic [LW-1:0]     w_level;

  dds_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_din   ({S_LAST, S_ADDR, S_DATA}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  assign {w_hlast, w_haddr, w_hdata} = w_head;

  assign S_READY = ~w_full & ~RST;
  assign w_push  = S_VALID & S_READY;
  assign w_end   = (r_cnt == '0);
  assign w_pop   = (r_state == ST_HOLD) & w_end;
  // Entries left once the head pops, counting a same-edge push
  assign w_more  = (w_level > LW'(1)) | w_push;
  assign w_ld    = (w_nxt != r_state);
  assign BUSY    = (r_state != ST_IDLE);
  assign DONE    = r_done;
  assign LEVEL   = w_level;

  always_comb begin
    w_len = '0;
    unique case (w_nxt)
      ST_MRESET: w_len = CW'(RST_CYCLES - 1);
      ST_SETUP:  w_len = CW'(T_SETUP - 1);
      ST_STROBE: w_len = CW'(T_WR - 1);
      ST_HOLD:   w_len = CW'(T_HOLD - 1);
      ST_UPDATE: w_len = CW'(UD_CYCLES - 1);
      default:   w_len = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_ld)        r_cnt <= w_len;
      else if (!w_end) r_cnt <= r_cnt - CW'(1);
      r_pend <= MR_REQ |
                (r_pend & ~(w_ld & (w_nxt == ST_MRESET)));
      r_done <= (r_state == ST_UPDATE) & w_end;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pend)        w_nxt = ST_MRESET;
        else if (!w_empty) w_nxt = ST_SETUP;
      end
      ST_MRESET: if (w_end) w_nxt = ST_IDLE;
      ST_SETUP:  if (w_end) w_nxt = ST_STROBE;
      ST_STROBE: if (w_end) w_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_end) begin
          if (w_hlast)     w_nxt = ST_UPDATE;
          else if (r_pend) w_nxt = ST_MRESET;
          else if (w_more) w_nxt = ST_SETUP;
          else             w_nxt = ST_IDLE;
        end
      end
      ST_UPDATE: if (w_end) w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    AOUT  = '0;
    DOUT  = '0;
    WRB   = 1'b1;
    RESET = 1'b0;
    UDCLK = 1'b0;
    unique case (r_state)
      ST_SETUP, ST_HOLD: begin
        AOUT = w_haddr;
        DOUT = w_hdata;
      end
      ST_STROBE: begin
        AOUT = w_haddr;
        DOUT = w_hdata;
        WRB  = 1'b0;
      end
      ST_MRESET: RESET = 1'b1;
      ST_UPDATE: UDCLK = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dds_par_writer.sv
// Scoreboard bench for dds_par_writer: bus events are queued at stimulus
// time and matched by a negedge monitor.
module tb_dds_par_writer;

  typedef enum int {EV_WR, EV_UPD, EV_RST} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [5:0] a;
    logic [7:0] d;
    int         len;
    int         gap;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S_VALID = 1'b0;
  logic       S_READY;
  logic [5:0] S_ADDR = '0;
  logic [7:0] S_DATA = '0;
  logic       S_LAST = 1'b0;
  logic       MR_REQ = 1'b0;
  logic [5:0] AOUT;
  logic [7:0] DOUT;
  logic       WRB;
  logic       RESET;
  logic       UDCLK;
  logic       BUSY;
  logic       DONE;
  logic [4:0] LEVEL;

  logic       p_valid = 1'b0;
  logic       p_ready;
  logic [5:0] p_addr = '0;
  logic [7:0] p_data = '0;
  logic       p_last = 1'b0;
  logic       p_mr = 1'b0;
  logic [5:0] p_aout;
  logic [7:0] p_dout;
  logic       p_wrb;
  logic       p_reset;
  logic       p_udclk;
  logic       p_busy;
  logic       p_done;
  logic [4:0] p_level;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  dds_par_writer u_dut (
    .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_ADDR(S_ADDR), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .MR_REQ(MR_REQ), .AOUT(AOUT), .DOUT(DOUT), .WRB(WRB),
    .RESET(RESET), .UDCLK(UDCLK), .BUSY(BUSY), .DONE(DONE),
    .LEVEL(LEVEL)
  );

  dds_par_writer #(.T_SETUP(1), .T_WR(3), .T_HOLD(2)) u_p (
    .CLK(CLK), .RST(RST), .S_VALID(p_valid), .S_READY(p_ready),
    .S_ADDR(p_addr), .S_DATA(p_data), .S_LAST(p_last),
    .MR_REQ(p_mr), .AOUT(p_aout), .DOUT(p_dout), .WRB(p_wrb),
    .RESET(p_reset), .UDCLK(p_udclk), .BUSY(p_busy), .DONE(p_done),
    .LEVEL(p_level)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_ev(input ev_kind_t k, input logic [5:0] a,
                        input logic [7:0] d, input int len,
                        input int gap);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.len = len; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic take(input ev_kind_t k, input logic [5:0] a,
                      input logic [7:0] d, input int len,
                      input int gap);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d actual=present required=none", k);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", k, e.kind);
    if (k == EV_WR && e.kind == EV_WR) begin
      chk("wr_addr", a, e.a);
      chk("wr_data", d, e.d);
    end
    chk("ev_len", len, e.len);
    if (e.gap > 0) chk("wr_gap", gap, e.gap);
  endtask

  int         m_cyc = 0;
  int         m_low = 0;
  int         m_ud = 0;
  int         m_rs = 0;
  int         m_rise = -100;
  logic       m_pw = 1'b1;
  logic       m_pu = 1'b0;
  logic       m_pr = 1'b0;
  logic [5:0] m_a = '0;
  logic [7:0] m_d = '0;

  always @(negedge CLK) begin
    m_cyc++;
    if (RST) begin
      m_low = 0; m_ud = 0; m_rs = 0; m_rise = -100;
      m_pw = 1'b1; m_pu = 1'b0; m_pr = 1'b0;
    end else begin
      if (!WRB) begin
        m_low++;
        m_a = AOUT;
        m_d = DOUT;
      end else if (!m_pw) begin
        chk("hold_addr", AOUT, m_a);
        chk("hold_data", DOUT, m_d);
        take(EV_WR, m_a, m_d, m_low, m_cyc - m_rise);
        m_low = 0;
        m_rise = m_cyc;
      end
      if (UDCLK) m_ud++;
      else if (m_pu) begin
        chk("done_pulse", DONE, 1);
        take(EV_UPD, 0, 0, m_ud, 0);
        m_ud = 0;
      end
      if (RESET) m_rs++;
      else if (m_pr) begin
        take(EV_RST, 0, 0, m_rs, 0);
        m_rs = 0;
      end
      m_pw = WRB; m_pu = UDCLK; m_pr = RESET;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [7:0] d,
                      input logic l, input bit qd, input int gap);
    int n = 0;
    S_VALID = 1'b1; S_ADDR = a; S_DATA = d; S_LAST = l;
    while (!S_READY && n < 100) begin
      tick();
      n++;
    end
    if (!S_READY) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_ready required=ready");
    end
    tick();
    S_VALID = 1'b0;
    if (qd) begin
      exp_ev(EV_WR, a, d, 2, gap);
      if (l) exp_ev(EV_UPD, 0, 0, 4, 0);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((q.size() != 0 || BUSY || LEVEL != 0) && n < 1000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(nm, q.size(), 0);
    chk("idle_busy", BUSY, 0);
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (WRB && n < 100) begin
      tick();
      n++;
    end
    chk("strobe_seen", WRB, 0);
  endtask

  initial begin
    int n;
    int bc;
    int lc;
    int ac;
    int fl;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wrb", WRB, 1);
    chk("rst_sready", S_READY, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_aout", AOUT, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_reset", RESET, 0);
    chk("rst_udclk", UDCLK, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    tick();
    chk("ready_after_rst", S_READY, 1);

    push(6'h04, 8'hA5, 1'b0, 1'b1, 0);
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      chk("sw_aout", AOUT, (c >= 1 && c <= 5) ? 6'h04 : 6'h00);
      chk("sw_dout", DOUT, (c >= 1 && c <= 5) ? 8'hA5 : 8'h00);
      chk("sw_wrb", WRB, (c == 3 || c == 4) ? 0 : 1);
      chk("sw_udclk", UDCLK, 0);
    end
    chk("sw_idle", BUSY, 0);
    wait_idle("single_drain");

    for (int i = 0; i < 6; i++)
      push(6'h09 - 6'(i), 8'h10 + 8'(i), i == 5, 1'b1, (i == 0) ? 0 : 5);
    wait_idle("burst_drain");

    push(6'h20, 8'h31, 1'b0, 1'b1, 0);
    push(6'h21, 8'h32, 1'b0, 1'b0, 0);
    push(6'h22, 8'h33, 1'b0, 1'b0, 0);
    wait_strobe();
    MR_REQ = 1'b1;
    tick();
    MR_REQ = 1'b0;
    exp_ev(EV_RST, 0, 0, 10, 0);
    exp_ev(EV_WR, 6'h21, 8'h32, 2, 0);
    exp_ev(EV_WR, 6'h22, 8'h33, 2, 5);
    wait_idle("mr_drain");

    exp_ev(EV_RST, 0, 0, 10, 0);
    exp_ev(EV_RST, 0, 0, 10, 0);
    MR_REQ = 1'b1;
    tick();
    MR_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      MR_REQ = (i == 5);
      push(6'(i), 8'h40 + 8'(i), 1'b0, 1'b1, (i == 0) ? 0 : 5);
    end
    MR_REQ = 1'b0;
    chk("full_sready", S_READY, 0);
    chk("full_level", LEVEL, 16);
    S_VALID = 1'b1; S_ADDR = 6'h10; S_DATA = 8'h50; S_LAST = 1'b0;
    n = 0;
    while (!S_READY && n < 50) begin
      tick();
      n++;
    end
    chk("full_wait_cycles", n, 12);
    chk("level_at_accept", LEVEL, 15);
    tick();
    S_VALID = 1'b0;
    exp_ev(EV_WR, 6'h10, 8'h50, 2, 5);
    chk("level_after_17", LEVEL, 16);
    wait_idle("full_drain");

    push(6'h30, 8'h61, 1'b0, 1'b0, 0);
    push(6'h31, 8'h62, 1'b0, 1'b0, 0);
    wait_strobe();
    chk("pre_rst_level", LEVEL, 2);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_wrb", WRB, 1);
    chk("arst_level", LEVEL, 0);
    chk("arst_aout", AOUT, 0);
    chk("arst_dout", DOUT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_reset", RESET, 0);
    chk("arst_udclk", UDCLK, 0);
    chk("arst_done", DONE, 0);
    chk("arst_sready", S_READY, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("post_arst_busy", BUSY, 0);
    chk("post_arst_level", LEVEL, 0);
    chk("post_arst_ready", S_READY, 1);

    p_valid = 1'b1; p_addr = 6'h15; p_data = 8'h7E;
    chk("p_ready", p_ready, 1);
    tick();
    p_valid = 1'b0;
    bc = 0; lc = 0; ac = 0; fl = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (p_busy) bc++;
      if (p_aout == 6'h15 && p_dout == 8'h7E) ac++;
      if (!p_wrb) begin
        lc++;
        if (fl < 0) fl = c;
      end
    end
    chk("sweep_busy_cycles", bc, 6);
    chk("sweep_wrb_low", lc, 3);
    chk("sweep_bus_cycles", ac, 6);
    chk("sweep_first_low", fl, 2);
    chk("sweep_udclk", p_udclk, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
